sevseg_scan_n: RTL and testbench

Parametrised multiplexed seven-segment driver. It is the next generation of the board's 4-digit hex scan driver and feeds the IO-board display from the clock datapath.
- Generalised to N digits with configurable anode and segment polarity.
- Adds per-digit blanking, decimal points, leading-zero suppression, PWM brightness, an anti-ghosting dead time and a frame strobe.

---
 rtl/sevseg_scan_n.sv | 174 +++++++++++++++++
 tb/tb_sevseg_scan_n.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_n.sv
// -----------------------------------------------------------------------------
// sevseg_scan_n
//   Multiplexed N-digit seven-segment scan driver with configurable anode and
//   segment polarity, per-digit blanking, decimal points, leading-zero
//   suppression, PWM brightness, anti-ghosting dead time and a frame strobe.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   digits_in    hex value per digit, nibble i = digit i (digit 0 rightmost)
//   dp_in        decimal point request per digit
//   blank_in     force digit i dark
//   lz_suppress  enable leading-zero suppression (digit 0 never suppressed)
//   brightness   PWM duty, 0 = dark, all-ones = full on
//   ANODE        digit select, bit i = digit i
//   CATHODE      segments gfedcba (bit 6 = g ... bit 0 = a)
//   DP           decimal point segment
//   frame_tick   one-cycle pulse per completed scan frame
// -----------------------------------------------------------------------------
module sevseg_scan_n #(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned REFRESH_CYCLES   = 100000,
  parameter int unsigned BLANK_CYCLES     = 1000,
  parameter int unsigned BRIGHT_W         = 4,
  parameter int unsigned ANODE_ACTIVE_LOW = 1,
  parameter int unsigned SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   ANODE,
  output logic [6:0]              CATHODE,
  output logic                    DP,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // XOR masks that map active-high internal values onto pin polarity;
  // they are also the "everything off" pin levels.
  localparam logic [NUM_DIGITS-1:0] ANODE_INV = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_INV   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_INV    = (SEG_ACTIVE_LOW != 0);

  // Active-high gfedcba pattern for a hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;

  // Per-slot snapshot of the digit being shown
  logic [3:0] snap_digit;
  logic       snap_dp;
  logic       snap_dark;

  // Combinational helpers
  logic [NUM_DIGITS-1:0] zero_run;
  logic [3:0]            live_digit;
  logic                  live_dp;
  logic                  live_dark;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_dark;
  logic                  pwm_on;
  logic                  lit;
  logic [NUM_DIGITS-1:0] sel;

  // zero_run[i] = every nibble from the top digit down to i is zero.
  always_comb begin
    logic run;
    run      = 1'b1;
    zero_run = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      run = run && (digits_in[(NUM_DIGITS-1-k)*4 +: 4] == 4'h0);
      zero_run[NUM_DIGITS-1-k] = run;
    end
  end

  always_comb begin
    live_digit = digits_in[{idx, 2'b00} +: 4];
    live_dp    = dp_in[idx];
    live_dark  = blank_in[idx] | (lz_suppress & (idx != '0) & zero_run[idx]);
  end

  // The snapshot registers load at the end of the slot_cnt==0 cycle, so during
  // that cycle the live values stand in for them; this keeps the first cycle
  // of a slot correct even when BLANK_CYCLES is 0.
  always_comb begin
    if (slot_cnt == '0) begin
      cur_digit = live_digit;
      cur_dp    = live_dp;
      cur_dark  = live_dark;
    end else begin
      cur_digit = snap_digit;
      cur_dp    = snap_dp;
      cur_dark  = snap_dark;
    end
  end

  always_comb begin
    pwm_on = (brightness == '1) || (pwm_cnt < brightness);
    lit    = (slot_cnt >= SLOT_BLANK) && !cur_dark && pwm_on;
    sel    = NUM_DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      snap_digit <= '0;
      snap_dp    <= 1'b0;
      snap_dark  <= 1'b1;
      ANODE      <= ANODE_INV;
      CATHODE    <= SEG_INV;
      DP         <= DP_INV;
      frame_tick <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;

      if (slot_cnt == '0) begin
        snap_digit <= live_digit;
        snap_dp    <= live_dp;
        snap_dark  <= live_dark;
      end

      if (slot_cnt == SLOT_LAST) begin
        slot_cnt   <= '0;
        idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        frame_tick <= (idx == IDX_LAST);
      end else begin
        slot_cnt   <= slot_cnt + 1'b1;
        frame_tick <= 1'b0;
      end

      ANODE   <= (lit ? sel : '0) ^ ANODE_INV;
      CATHODE <= (lit ? seg_decode(cur_digit) : 7'b0) ^ SEG_INV;
      DP      <= (lit & cur_dp) ^ DP_INV;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_n.sv
// -----------------------------------------------------------------------------
// tb_sevseg_scan_n
//   Self-checking bench for sevseg_scan_n with NUM_DIGITS=4, REFRESH_CYCLES=8,
//   BLANK_CYCLES=2, BRIGHT_W=2 and both polarities active-low. A cycle model
//   predicts the outputs for every clock, pushes them to a scoreboard queue
//   and the popped values are compared after the edge; directed checks cover
//   the documented scenarios on top of that.
// -----------------------------------------------------------------------------
module tb_sevseg_scan_n;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [3:0]  ANODE;
  logic [6:0]  CATHODE;
  logic        DP;
  logic        frame_tick;

  sevseg_scan_n #(
    .NUM_DIGITS      (4),
    .REFRESH_CYCLES  (8),
    .BLANK_CYCLES    (2),
    .BRIGHT_W        (2),
    .ANODE_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_suppress(lz_suppress),
    .brightness (brightness),
    .ANODE      (ANODE),
    .CATHODE    (CATHODE),
    .DP         (DP),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] ca;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  // Active-high gfedcba table, index = hex value
  logic [6:0] segtab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Model state
  int         m_s, m_d, m_p;
  logic [3:0] m_val;
  logic       m_dk, m_dpv;
  int         last_pwm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] nib(input int i);
    logic [15:0] d;
    d = digits_in;
    return d[i*4 +: 4];
  endfunction

  function automatic logic dark_of(input int i);
    logic z;
    z = 1'b1;
    for (int j = i; j < 4; j++)
      if (nib(j) != 4'h0) z = 1'b0;
    return blank_in[i] || (lz_suppress && (i != 0) && z);
  endfunction

  task automatic model_reset();
    m_s = 0; m_d = 0; m_p = 0;
    m_val = 4'h0; m_dk = 1'b1; m_dpv = 1'b0;
  endtask

  // One clock: predict, advance, compare.
  task automatic tick();
    exp_t       e;
    exp_t       got;
    logic [3:0] v;
    logic       dk, dpv, pon, lt;
    if (m_s == 0) begin
      v = nib(m_d); dk = dark_of(m_d); dpv = dp_in[m_d];
    end else begin
      v = m_val; dk = m_dk; dpv = m_dpv;
    end
    pon  = (brightness == 2'b11) || (m_p < int'(brightness));
    lt   = (m_s >= 2) && !dk && pon;
    e.an = lt ? ~(4'b0001 << m_d) : 4'b1111;
    e.ca = lt ? ~segtab[v] : 7'h7f;
    e.dp = !(lt && dpv);
    e.ft = (m_s == 7) && (m_d == 3);
    sbq.push_back(e);
    last_pwm = m_p;

    @(posedge clk);
    #1;

    if (m_s == 0) begin
      m_val = v; m_dk = dk; m_dpv = dpv;
    end
    if (m_s == 7) begin
      m_s = 0;
      m_d = (m_d + 1) % 4;
    end else begin
      m_s++;
    end
    m_p = (m_p + 1) % 4;

    got = sbq.pop_front();
    check("anode", 32'(ANODE), 32'(got.an));
    check("cathode", 32'(CATHODE), 32'(got.ca));
    check("dp", 32'(DP), 32'(got.dp));
    check("frame_tick", 32'(frame_tick), 32'(got.ft));
    check("onehot", 32'($countones(~ANODE) <= 1), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] t1_an [11] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                             4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
  logic [3:0] any_low;
  logic [6:0] cath0;
  int         ft_cnt, ft_first, ft_second, lit_cnt;
  logic       flag, seen;

  initial begin
    rst_n       = 1'b0;
    digits_in   = 16'h1234;
    dp_in       = 4'b0000;
    blank_in    = 4'b0000;
    lz_suppress = 1'b0;
    brightness  = 2'b11;
    model_reset();
    last_pwm    = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_anode", 32'(ANODE), 32'hF);
    check("rst_cathode", 32'(CATHODE), 32'h7F);
    check("rst_dp", 32'(DP), 32'd1);
    check("rst_ft", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Start-up sequence after reset release
    for (int t = 0; t < 11; t++) begin
      tick();
      check("t1_anode_seq", 32'(ANODE), 32'(t1_an[t]));
      if (t == 2)  check("t1_digit0_four", 32'(CATHODE), 32'h19);
      if (t == 10) check("t1_digit1_three", 32'(CATHODE), 32'h30);
    end
    tick();
    check("t1_anode_1101", 32'(ANODE), 32'hD);

    // Asynchronous reset mid-slot, no clock edge in between
    rst_n = 1'b0;
    #2;
    check("arst_anode", 32'(ANODE), 32'hF);
    check("arst_cathode", 32'(CATHODE), 32'h7F);
    check("arst_dp", 32'(DP), 32'd1);
    @(posedge clk);
    #1;
    check("arst_hold_anode", 32'(ANODE), 32'hF);
    rst_n = 1'b1;
    model_reset();

    // Mid-slot digit change shows only at that digit's next slot
    ticks(5);
    check("mid_anode", 32'(ANODE), 32'hE);
    digits_in = 16'h1239;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("mid_hold_four", 32'(CATHODE), 32'h19);
    end
    ticks(27);
    check("mid_next_anode", 32'(ANODE), 32'hE);
    check("mid_next_nine", 32'(CATHODE), 32'h10);

    // Scan wrap and frame strobe
    ft_cnt = 0; ft_first = -1; ft_second = -1;
    for (int t = 0; t < 64; t++) begin
      tick();
      if (frame_tick) begin
        if (ft_cnt == 0) ft_first = t; else ft_second = t;
        ft_cnt++;
      end
    end
    check("ft_count", 32'(ft_cnt), 32'd2);
    check("ft_spacing", 32'(ft_second - ft_first), 32'd32);

    // Leading-zero suppression, one visible digit
    digits_in   = 16'h0005;
    lz_suppress = 1'b1;
    ticks(32);
    any_low = 4'b0; cath0 = 7'h7F;
    for (int t = 0; t < 32; t++) begin
      tick();
      any_low |= ~ANODE;
      if (ANODE == 4'hE) cath0 = CATHODE;
    end
    check("lz5_lit_digits", 32'(any_low), 32'h1);
    check("lz5_digit0", 32'(cath0), 32'h12);

    // All zeros still shows a single "0"
    digits_in = 16'h0000;
    ticks(32);
    any_low = 4'b0; cath0 = 7'h7F;
    for (int t = 0; t < 32; t++) begin
      tick();
      any_low |= ~ANODE;
      if (ANODE == 4'hE) cath0 = CATHODE;
    end
    check("lz0_lit_digits", 32'(any_low), 32'h1);
    check("lz0_digit0", 32'(cath0), 32'h40);

    // Blanking and decimal point
    digits_in   = 16'h1234;
    lz_suppress = 1'b0;
    blank_in    = 4'b0100;
    dp_in       = 4'b0001;
    ticks(32);
    any_low = 4'b0; flag = 1'b0; seen = 1'b0;
    for (int t = 0; t < 32; t++) begin
      tick();
      any_low |= ~ANODE;
      if (!DP && ANODE != 4'hE) flag = 1'b1;
      if (!DP) seen = 1'b1;
    end
    check("blank_lit_digits", 32'(any_low), 32'hB);
    check("dp_only_digit0", 32'(flag), 32'd0);
    check("dp_seen", 32'(seen), 32'd1);

    // PWM at quarter duty: pwm phase equals slot phase, so only slot step 4 lights
    blank_in   = 4'b0000;
    dp_in      = 4'b0000;
    brightness = 2'b01;
    ticks(32);
    flag = 1'b0; lit_cnt = 0;
    for (int t = 0; t < 32; t++) begin
      tick();
      if (ANODE != 4'hF) begin
        lit_cnt++;
        if (last_pwm != 0) flag = 1'b1;
      end
    end
    check("pwm1_phase", 32'(flag), 32'd0);
    check("pwm1_lit_count", 32'(lit_cnt), 32'd4);

    // Brightness 0 keeps the display dark
    brightness = 2'b00;
    ticks(2);
    any_low = 4'b0;
    for (int t = 0; t < 32; t++) begin
      tick();
      any_low |= ~ANODE;
    end
    check("pwm0_dark", 32'(any_low), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
